servo_pwm_gen: RTL



---
 rtl/servo_pkg.sv | 40 ++++
 rtl/servo_pwm_gen_if.sv | 17 +
 rtl/servo_tick_gen.sv | 37 +++
 rtl/servo_pwm_gen.sv | 110 +++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: shared constants, FSM state type and position helpers for the
// servo PWM generator.
//   POS_MAX / POS_RESET : angle limit and reset angle (degrees)
//   *_DEF               : default parameter values for servo_pwm_gen
//   servo_state_e       : OFF / HIGH / LOW frame states
//   clamp_pos           : limit a requested angle to 0..POS_MAX
//   slew_step           : move an angle toward a target by at most 'step'
package servo_pkg;

    localparam int POS_MAX        = 180;
    localparam int POS_RESET      = 50;

    localparam int CLK_PER_US_DEF = 50;
    localparam int FRAME_US_DEF   = 20000;
    localparam int MIN_US_DEF     = 500;
    localparam int US_PER_DEG_DEF = 10;
    localparam int SLEW_DEG_DEF   = 2;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } servo_state_e;

    function automatic logic [7:0] clamp_pos(input logic [7:0] p);
        return (p > 8'(POS_MAX)) ? 8'(POS_MAX) : p;
    endfunction

    // cur and tgt are both <= POS_MAX, so cur+step only happens when it stays
    // below tgt and cur-step only when it stays above tgt: no wrap possible.
    function automatic logic [7:0] slew_step(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
        if (tgt > cur)
            return ((tgt - cur) > step) ? (cur + step) : tgt;
        else
            return ((cur - tgt) > step) ? (cur - step) : tgt;
    endfunction

endpackage

// File: rtl/servo_pwm_gen_if.sv
// servo_pwm_gen_if: control/status bundle of the servo PWM generator.
//   pos         : target angle in degrees (controller -> generator)
//   enable      : allow PWM frames to run (controller -> generator)
//   pwm         : servo control pulse (generator -> controller)
//   frame_start : one-cycle strobe on the first clock of each frame
//   pos_applied : angle latched for the current frame
// master = the controller side, slave = the generator.
interface servo_pwm_gen_if;
    logic [7:0] pos;
    logic       enable;
    logic       pwm;
    logic       frame_start;
    logic [7:0] pos_applied;

    modport master (output pos, enable, input  pwm, frame_start, pos_applied);
    modport slave  (input  pos, enable, output pwm, frame_start, pos_applied);
endinterface

// File: rtl/servo_tick_gen.sv
// servo_tick_gen: microsecond prescaler.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count at 0 on the next edge (frame start)
//   run        : count while high, held at 0 while low
//   tick       : one-cycle pulse every CLK_PER_US clocks while running
module servo_tick_gen
    import servo_pkg::*;
#(
    parameter int CLK_PER_US = CLK_PER_US_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int CW = $clog2(CLK_PER_US + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == CW'(CLK_PER_US - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !run)
            cnt_d = '0;
        else if (tick)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: hobby-servo PWM frame generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : servo_pwm_gen_if.slave (pos, enable in; pwm, frame_start,
//                pos_applied out)
// Each frame lasts FRAME_US microseconds; pwm is high for
// MIN_US + pos_applied*US_PER_DEG microseconds at the start of the frame.
// The target angle is sampled and clamped only at frame start, and a frame
// always runs to completion once begun.
// Build option: define SERVO_SLEW_EN to limit the change of pos_applied to
// SLEW_DEG degrees per frame.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int CLK_PER_US = CLK_PER_US_DEF,
    parameter int FRAME_US   = FRAME_US_DEF,
    parameter int MIN_US     = MIN_US_DEF,
    parameter int US_PER_DEG = US_PER_DEG_DEF,
    parameter int SLEW_DEG   = SLEW_DEG_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    servo_pwm_gen_if.slave  bus
);
    // Counter width covers both the frame length and the widest pulse.
    localparam int WMAX = MIN_US + POS_MAX * US_PER_DEG;
    localparam int UMAX = (FRAME_US > WMAX) ? FRAME_US : WMAX;
    localparam int UW   = $clog2(UMAX + 1);

    servo_state_e  state_q, state_d;
    logic [UW-1:0] us_cnt_q, us_cnt_d, us_next, width_us;
    logic [7:0]    pos_applied_q, pos_applied_d, pos_tgt, pos_load;
    logic          frame_start_q, frame_start_d;
    logic          start_frame, tick, run;

    assign run = (state_q != OFF);

    servo_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_frame),
        .run   (run),
        .tick  (tick)
    );

    assign width_us = UW'(MIN_US) + UW'(pos_applied_q) * UW'(US_PER_DEG);
    assign us_next  = us_cnt_q + UW'(1);
    assign pos_tgt  = clamp_pos(bus.pos);

`ifdef SERVO_SLEW_EN
    assign pos_load = slew_step(pos_applied_q, pos_tgt, 8'(SLEW_DEG));
`else
    assign pos_load = pos_tgt;
`endif

    always_comb begin
        state_d       = state_q;
        us_cnt_d      = us_cnt_q;
        pos_applied_d = pos_applied_q;
        start_frame   = 1'b0;
        case (state_q)
            OFF: begin
                if (bus.enable) start_frame = 1'b1;
            end
            HIGH, LOW: begin
                // us_cnt counts completed microseconds; act on the tick that
                // completes the next one so phase lengths are exact.
                if (tick) begin
                    us_cnt_d = us_next;
                    if (us_next == UW'(FRAME_US)) begin
                        if (bus.enable) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d  = OFF;
                            us_cnt_d = '0;
                        end
                    end else if (state_q == HIGH && us_next >= width_us) begin
                        state_d = LOW;
                    end
                end
            end
            default: state_d = OFF;
        endcase
        if (start_frame) begin
            state_d       = HIGH;
            us_cnt_d      = '0;
            pos_applied_d = pos_load;
        end
        frame_start_d = start_frame;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= OFF;
            us_cnt_q      <= '0;
            pos_applied_q <= 8'(POS_RESET);
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            us_cnt_q      <= us_cnt_d;
            pos_applied_q <= pos_applied_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Decoded straight from the async-reset state register so reset drops
    // the pulse immediately.
    assign bus.pwm         = (state_q == HIGH);
    assign bus.frame_start = frame_start_q;
    assign bus.pos_applied = pos_applied_q;
endmodule
